demux_frame_sequencer: RTL
==========================

# demux_frame_sequencer

Upstream driver for the 1-to-8 gate-level demultiplexer. Accepts 8-bit frames over a valid/ready handshake and buffers one frame. Replays each frame bit-by-bit onto `dataIn`/`selectLine`, channel 0 to 7, holding each channel for a programmable dwell, so the demux fans the frame out across its eight outputs. Signals frame completion and supports back-to-back frames without bubbles.

## Interface
Parameters:
- `DWELL`, default 1: cycles each channel is driven; legal range 1..16.
- `GAP`, default 0: idle cycles inserted after each frame; legal range 0..15.

Ports:
- `clock`  in  1: single clock, rising-edge.
- `resetN`  in  1: asynchronous, active-low reset.
- `frameIn`  in  8: frame payload; bit i goes to channel i.
- `frameValid`  in  1: upstream offers `frameIn`.
- `frameReady`  out  1: one-entry hold buffer is empty; frame accepted on `frameValid && frameReady` at a rising edge.
- `dataIn`  out  1: bit to the demux data input.
- `selectLine`  out  3: channel select to the demux.
- `active`  out  1: high while a channel is being driven.
- `frameDone`  out  1: one-cycle pulse after the last channel of a frame.

## Operation
- Hold buffer: one register with a full flag. Set on handshake; cleared when the FSM loads it.
- `frameReady` = !holdFull (combinational from the flag). It cannot accept and drain in the same cycle.
- Work register: holds the frame currently being driven, a 3-bit channel counter `ch`, a 4-bit dwell counter, and a 4-bit gap counter.
- FSM states: IDLE, DRIVE, GAP.
  - IDLE: if holdFull, load work register from hold, clear holdFull, set `ch`=0 and dwell=0, then go to DRIVE. Otherwise stay in IDLE.
  - DRIVE: dwell counts 0..DWELL-1. At DWELL-1, `ch` increments and dwell clears.
    - At `ch`=7 with dwell=DWELL-1, the frame ends: pulse `frameDone`.
    - Then, if GAP>0, go to GAP with the gap counter at 0.
    - Else if holdFull, load the next frame and stay in DRIVE (`ch`=0).
    - Else go to IDLE.
  - GAP: count 0..GAP-1, then take the same holdFull/IDLE decision as above.
- Outputs are registered.
  - DRIVE: `dataIn`=work[ch], `selectLine`=ch, `active`=1.
  - IDLE and GAP: `dataIn`=0, `selectLine`=0, `active`=0, so every demux output is 0.
- `ch` never wraps within a frame. It is reloaded to 0 on each frame load.
- Upstream must hold `frameIn` stable while `frameValid` is high and not accepted. Dropping `frameValid` before acceptance is legal; no frame is taken.

## Timing
- Reset values, all asynchronous: state=IDLE, holdFull=0, `frameReady`=1, `dataIn`=0, `selectLine`=0, `active`=0, `frameDone`=0.
- Reset mid-frame: aborts immediately. Buffered and in-flight frames are discarded and `frameDone` is not pulsed.
- Latency from IDLE: handshake in cycle 0.
  - Cycle 1: holdFull=1, `frameReady`=0.
  - Cycle 2: first DRIVE cycle (ch 0); `frameReady`=1 again.
  - Last DRIVE cycle is 1+8·DWELL.
  - `frameDone` is high in cycle 2+8·DWELL.
- Back-to-back (GAP=0, next frame buffered): channel 0 of the next frame is driven in the cycle after channel 7 of the previous one. Sustained throughput is one frame per 8·DWELL cycles. `frameDone` of frame N coincides with channel 0 of frame N+1.
- With GAP>0: the next frame starts GAP cycles after the last DRIVE cycle at the earliest.
- Handshake in the same cycle as a frame end: the frame is buffered and starts after the following frame end, or from IDLE (2 cycles later).

## Structure
- Package `demux_seq_pkg`: state enum typedef (IDLE, DRIVE, GAP), `CH_COUNT`=8, `SEL_W`=3, `CNT_W`=4.
- Sub-module `frame_hold_buffer`: one-entry register with full flag and valid/ready front end. Load/clear is driven by the FSM.
- Top level holds the FSM, counters and output registers.

## Test plan
- Reset release with `frameValid`=0: `frameReady`=1, `active`=0, `selectLine`=0, `dataIn`=0 indefinitely.
- DWELL=1, GAP=0, single frame 8'hA5 accepted cycle 0:
  - `selectLine`=0..7 in cycles 2..9.
  - `dataIn`=1,0,1,0,0,1,0,1.
  - `frameDone` high only in cycle 10.
  - `active` low from cycle 10.
- DWELL=3: frame 8'h81.
  - Each `selectLine` value is held 3 cycles.
  - `dataIn`=1 only for ch 0 and ch 7.
  - `frameDone` in cycle 26.
- GAP=0, frames 8'hFF then 8'h00 offered back-to-back:
  - 16 consecutive `active` cycles.
  - `frameReady` low in cycles 1 and 3.
  - `frameDone` in cycles 10 and 18.
- GAP=2, two buffered frames: exactly 2 cycles with `active`=0 and `selectLine`=0 between the frames.
- Assert `resetN` low in cycle 5 of a frame while a second frame is buffered:
  - Outputs are 0 immediately; `frameReady`=1.
  - No `frameDone` pulse.
  - Neither frame resumes after reset release.

Source files
------------

// File: rtl/demux_frame_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// demux_seq_pkg
// Shared definitions for the demux frame sequencer: sequencer FSM state
// encoding, channel count and the counter/select widths, plus a helper that
// turns a cycle count into the terminal value of a zero-based counter.
// Ports: none (package).
// ---------------------------------------------------------------------------
package demux_seq_pkg;

    localparam int CH_COUNT = 8;   // demux outputs, one frame bit each
    localparam int SEL_W    = 3;   // width of the channel select
    localparam int CNT_W    = 4;   // width of the dwell and gap counters

    // ST_IDLE: nothing to drive; ST_DRIVE: replaying a frame; ST_GAP: idle spacing
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } seq_state_t;

    // Terminal value of a counter that runs 0..n-1. For n=0 the counter is
    // never used, so zero is returned to keep the constant in range.
    function automatic logic [CNT_W-1:0] last_count(input int n);
        return (n > 0) ? CNT_W'(n - 1) : '0;
    endfunction

endpackage

// File: rtl/demux_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// demux_frame_sequencer_if
// Bundles the frame handshake and the demux drive signals.
//   frameIn    : frame payload, bit i goes to demux channel i
//   frameValid : upstream offers frameIn
//   frameReady : sequencer can take a frame
//   dataIn     : bit presented to the demux data input
//   selectLine : channel select presented to the demux
//   active     : a channel is being driven this cycle
//   frameDone  : one-cycle pulse after the last channel of a frame
//   fsm_state  : sequencer FSM state, for observation only
// Handshake: a frame transfers on every rising edge where frameValid and
// frameReady are both high. While frameValid is high and not yet accepted the
// upstream keeps frameIn stable; it may drop frameValid before acceptance, in
// which case nothing is transferred. frameReady does not depend on frameValid.
// Modports: master = upstream/driver side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface demux_frame_sequencer_if;
    import demux_seq_pkg::*;

    logic [CH_COUNT-1:0] frameIn;
    logic                frameValid;
    logic                frameReady;
    logic                dataIn;
    logic [SEL_W-1:0]    selectLine;
    logic                active;
    logic                frameDone;
    seq_state_t          fsm_state;

    modport master (
        output frameIn, frameValid,
        input  frameReady, dataIn, selectLine, active, frameDone, fsm_state
    );

    modport slave (
        input  frameIn, frameValid,
        output frameReady, dataIn, selectLine, active, frameDone, fsm_state
    );

endinterface

// File: rtl/demux_frame_sequencer_hold_buffer.sv
// ---------------------------------------------------------------------------
// frame_hold_buffer
// One-entry frame buffer with a full flag. It fills on a valid/ready
// handshake and empties when the sequencer loads it into its work register.
//   clock       : rising-edge clock
//   resetN      : asynchronous active-low reset, empties the buffer
//   frame_in    : frame payload offered by upstream
//   frame_valid : upstream offers frame_in
//   frame_ready : buffer empty (= !hold_full)
//   load        : sequencer takes the buffered frame this cycle
//   hold_data   : buffered frame
//   hold_full   : buffer holds a frame
// ---------------------------------------------------------------------------
module frame_hold_buffer
    import demux_seq_pkg::*;
(
    input  logic                clock,
    input  logic                resetN,
    input  logic [CH_COUNT-1:0] frame_in,
    input  logic                frame_valid,
    output logic                frame_ready,
    input  logic                load,
    output logic [CH_COUNT-1:0] hold_data,
    output logic                hold_full
);

    // Ready only when empty, so a fill and a drain never meet in one cycle.
    assign frame_ready = !hold_full;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            hold_data <= '0;
            hold_full <= 1'b0;
        end else if (frame_valid && frame_ready) begin
            hold_data <= frame_in;
            hold_full <= 1'b1;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_frame_sequencer.sv
// ---------------------------------------------------------------------------
// demux_frame_sequencer
// Upstream driver for a 1-to-8 demultiplexer. Buffers one 8-bit frame and
// replays it bit by bit, channel 0 to 7, holding each channel DWELL cycles,
// then optionally idles GAP cycles before the next frame. A buffered frame
// starts in the cycle right after the previous frame when GAP is 0.
// Parameters:
//   DWELL : cycles each channel is driven, 1..16
//   GAP   : idle cycles after each frame, 0..15
// Ports:
//   clock  : rising-edge clock
//   resetN : asynchronous active-low reset; aborts any frame in progress
//   bus    : slave side of demux_frame_sequencer_if (handshake + demux drive)
// ---------------------------------------------------------------------------
module demux_frame_sequencer
    import demux_seq_pkg::*;
#(
    parameter int DWELL = 1,
    parameter int GAP   = 0
) (
    input logic                      clock,
    input logic                      resetN,
    demux_frame_sequencer_if.slave   bus
);

    localparam logic [CNT_W-1:0] DWELL_LAST = last_count(DWELL);
    localparam logic [CNT_W-1:0] GAP_LAST   = last_count(GAP);
    localparam logic [SEL_W-1:0] LAST_CH    = SEL_W'(CH_COUNT - 1);

    seq_state_t          state_q, state_n;
    logic [CH_COUNT-1:0] work_q, work_n;
    logic [SEL_W-1:0]    ch_q, ch_n;
    logic [CNT_W-1:0]    dwell_q, dwell_n;
    logic [CNT_W-1:0]    gap_q, gap_n;

    logic                load;
    logic                frame_end;
    logic                pick_next;
    logic [CH_COUNT-1:0] hold_data;
    logic                hold_full;

    logic                data_q, active_q, done_q;
    logic [SEL_W-1:0]    sel_q;
    logic                drive_n;

    frame_hold_buffer u_hold (
        .clock       (clock),
        .resetN      (resetN),
        .frame_in    (bus.frameIn),
        .frame_valid (bus.frameValid),
        .frame_ready (bus.frameReady),
        .load        (load),
        .hold_data   (hold_data),
        .hold_full   (hold_full)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            ch_q    <= '0;
            dwell_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_n;
            work_q  <= work_n;
            ch_q    <= ch_n;
            dwell_q <= dwell_n;
            gap_q   <= gap_n;
        end
    end

    // pick_next marks every point where the sequencer decides between
    // starting a buffered frame and going idle: in IDLE, at a frame end with
    // no gap, and at the end of the gap.
    always_comb begin
        state_n   = state_q;
        work_n    = work_q;
        ch_n      = ch_q;
        dwell_n   = dwell_q;
        gap_n     = gap_q;
        load      = 1'b0;
        frame_end = 1'b0;
        pick_next = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pick_next = 1'b1;
            end
            ST_DRIVE: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_n = '0;
                    if (ch_q == LAST_CH) begin
                        frame_end = 1'b1;
                        if (GAP > 0) begin
                            state_n = ST_GAP;
                            gap_n   = '0;
                        end else begin
                            pick_next = 1'b1;
                        end
                    end else begin
                        ch_n = ch_q + 1'b1;
                    end
                end else begin
                    dwell_n = dwell_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    pick_next = 1'b1;
                end else begin
                    gap_n = gap_q + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (pick_next) begin
            if (hold_full) begin
                load    = 1'b1;
                work_n  = hold_data;
                ch_n    = '0;
                dwell_n = '0;
                state_n = ST_DRIVE;
            end else begin
                state_n = ST_IDLE;
            end
        end
    end

    // Outputs are registered from the next-state values so they line up
    // with the state they describe rather than trailing it by a cycle.
    assign drive_n = (state_n == ST_DRIVE);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            data_q   <= 1'b0;
            sel_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            data_q   <= drive_n & work_n[ch_n];
            sel_q    <= drive_n ? ch_n : '0;
            active_q <= drive_n;
            done_q   <= frame_end;
        end
    end

    assign bus.dataIn     = data_q;
    assign bus.selectLine = sel_q;
    assign bus.active     = active_q;
    assign bus.frameDone  = done_q;
    assign bus.fsm_state  = state_q;

endmodule
